// File: rtl/pl_lsu_pkg.sv
// Shared constants for the memory-stage load/store unit: funct3 codes,
// FSM state encoding and byte-enable patterns.
package pl_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word.
  function automatic logic isAligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   return ~off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pl_lsu_align.sv
// Combinational lane logic: legality/alignment check, store byte-enable and
// data steering, and load byte/half extraction with sign or zero extension.
module pl_lsu_align
  import pl_lsu_pkg::*;
(
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [1:0]  addrLo,
  input  logic [31:0] WriteDataM,
  output logic        accValid,
  output logic        accIllegal,
  output logic [3:0]  reqBe,
  output logic [31:0] reqWdata,
  input  logic [2:0]  ldFunct3,
  input  logic [1:0]  ldOff,
  input  logic [31:0] rdata,
  output logic [31:0] ldData
);

  logic       access;
  logic       legal;
  logic       aligned;
  logic [7:0] ldByte;
  logic [15:0] ldHalf;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    legal = 1'b0;
    if (MemWriteM)
      legal = funct3M inside {F3_SB, F3_SH, F3_SW};
    else if (MemReadM)
      legal = funct3M inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  end

  assign access     = MemReadM | MemWriteM;
  assign aligned    = isAligned(funct3M[1:0], addrLo);
  assign accValid   = access & legal & aligned;
  assign accIllegal = access & ~(legal & aligned);

  always_comb begin
    reqBe    = BE_WORD;
    reqWdata = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        reqBe    = BE_BYTE << addrLo;
        reqWdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        reqBe    = addrLo[1] ? BE_HALF_HI : BE_HALF_LO;
        reqWdata = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  assign ldByte = rdata[8*ldOff +: 8];
  assign ldHalf = ldOff[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ldData = rdata;
    case (ldFunct3)
      F3_LB:   ldData = {{24{ldByte[7]}}, ldByte};
      F3_LH:   ldData = {{16{ldHalf[15]}}, ldHalf};
      F3_LBU:  ldData = {24'h0, ldByte};
      F3_LHU:  ldData = {16'h0, ldHalf};
      default: ;
    endcase
  end

endmodule

// File: rtl/pl_dmem_lsu.sv
// Memory-stage load/store unit: turns a pipeline load/store into a held
// req/ack transaction, stalls the pipeline until it completes, and times out.
module pl_dmem_lsu
  import pl_lsu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          regLoad;
  logic [2:0]    regFunct3;
  logic [1:0]    regOff;
  logic          accValid;
  logic          accIllegal;
  logic [3:0]    reqBe;
  logic [31:0]   reqWdata;
  logic [31:0]   ldData;
  logic          timeout;

  pl_lsu_align u_align (
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .addrLo     (ALUResultM[1:0]),
    .WriteDataM (WriteDataM),
    .accValid   (accValid),
    .accIllegal (accIllegal),
    .reqBe      (reqBe),
    .reqWdata   (reqWdata),
    .ldFunct3   (regFunct3),
    .ldOff      (regOff),
    .rdata      (dmem_rdata),
    .ldData     (ldData)
  );

  assign timeout   = (ACK_TIMEOUT != 0) && (cnt == CNT_LAST);
  assign StallM    = ((state == S_IDLE) && accValid) || (state == S_BUSY);
  assign MisalignM = (state == S_IDLE) && accIllegal;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= BE_NONE;
      regLoad    <= 1'b0;
      regFunct3  <= '0;
      regOff     <= '0;
      ReadDataM  <= '0;
      BusErrM    <= 1'b0;
    end else begin
      BusErrM <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accValid) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWriteM;
            dmem_addr  <= {ALUResultM[31:2], 2'b00};
            dmem_be    <= reqBe;
            dmem_wdata <= reqWdata;
            regLoad    <= ~MemWriteM;
            regFunct3  <= funct3M;
            regOff     <= ALUResultM[1:0];
            cnt        <= '0;
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_be  <= BE_NONE;
            if (regLoad) ReadDataM <= ldData;
            state    <= S_DONE;
          end else if (timeout) begin
            dmem_req <= 1'b0;
            dmem_be  <= BE_NONE;
            BusErrM  <= 1'b1;
            if (regLoad) ReadDataM <= ERR_DATA;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // The pipeline advances on this edge; inputs still show the old op.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pl_dmem_lsu.sv
// Scoreboard bench for pl_dmem_lsu: stimulus queues expected requests and
// completions, a negedge monitor compares them as the DUT presents them.
module tb_pl_dmem_lsu;

  localparam int TMO = 4;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;

  pl_dmem_lsu #(.ACK_TIMEOUT(TMO), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } reqExp_t;

  typedef struct {
    logic [31:0] rd;
    logic        busErr;
    int          stall;
    int          reqCyc;
  } cmpExp_t;

  reqExp_t reqQ[$];
  cmpExp_t cmpQ[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] expRd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares requests as they rise and completions when stall drops.
  logic    prevStall = 1'b0;
  logic    prevReq   = 1'b0;
  int      stallCnt  = 0;
  int      reqCnt    = 0;
  reqExp_t r;
  cmpExp_t c;

  always @(negedge clk) begin
    if (reset) begin
      prevStall = 1'b0;
      prevReq   = 1'b0;
      stallCnt  = 0;
      reqCnt    = 0;
    end else begin
      if (StallM) stallCnt++;
      if (dmem_req) reqCnt++;
      if (dmem_req && !prevReq) begin
        if (reqQ.size() == 0) begin
          check("unexpected req", 32'd1, 32'd0);
        end else begin
          r = reqQ.pop_front();
          check("req we", {31'd0, dmem_we}, {31'd0, r.we});
          check("req addr", dmem_addr, r.addr);
          if (r.we) begin
            check("req be", {28'd0, dmem_be}, {28'd0, r.be});
            check("req wdata", dmem_wdata, r.wdata);
          end
        end
      end
      if (prevStall && !StallM) begin
        if (cmpQ.size() == 0) begin
          check("unexpected done", 32'd1, 32'd0);
        end else begin
          c = cmpQ.pop_front();
          check("done ReadDataM", ReadDataM, c.rd);
          check("done BusErrM", {31'd0, BusErrM}, {31'd0, c.busErr});
          check("stall cycles", stallCnt, c.stall);
          check("req cycles", reqCnt, c.reqCyc);
        end
        stallCnt = 0;
        reqCnt   = 0;
      end
      prevStall = StallM;
      prevReq   = dmem_req;
    end
  end

  task automatic idleInputs();
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    funct3M    = 3'b000;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
  endtask

  // Issue one legal access from IDLE; ackAt = BUSY cycle carrying ack, 0 = never.
  task automatic doOp(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rdata, input int ackAt,
                      input logic [3:0] expBe, input logic [31:0] expWd,
                      input logic [31:0] expRdNew);
    reqExp_t re;
    cmpExp_t ce;
    int      busy;
    busy      = (ackAt == 0) ? TMO : ackAt;
    re.we     = wr;
    re.addr   = {addr[31:2], 2'b00};
    re.be     = expBe;
    re.wdata  = expWd;
    ce.rd     = expRdNew;
    ce.busErr = (ackAt == 0);
    ce.stall  = busy + 1;
    ce.reqCyc = busy;
    reqQ.push_back(re);
    cmpQ.push_back(ce);
    MemReadM   = rd;
    MemWriteM  = wr;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    dmem_rdata = rdata;
    #1;
    check("idle stall", {31'd0, StallM}, 32'd1);
    check("idle misalign", {31'd0, MisalignM}, 32'd0);
    @(posedge clk); #1;
    for (int i = 1; i <= busy; i++) begin
      dmem_ack = (i == ackAt);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    idleInputs();
    check("buserr low after", {31'd0, BusErrM}, 32'd0);
    expRd = expRdNew;
  endtask

  task automatic doBad(input string name, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] addr);
    MemReadM   = rd;
    MemWriteM  = wr;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = 32'h5A5A5A5A;
    #1;
    check({name, " misalign"}, {31'd0, MisalignM}, 32'd1);
    check({name, " stall"}, {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    check({name, " req"}, {31'd0, dmem_req}, 32'd0);
    check({name, " rd hold"}, ReadDataM, expRd);
    idleInputs();
  endtask

  initial begin
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    expRd      = 32'h0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst req", {31'd0, dmem_req}, 32'd0);
    check("rst be", {28'd0, dmem_be}, 32'd0);
    check("rst addr", dmem_addr, 32'd0);
    check("rst ReadDataM", ReadDataM, 32'd0);
    check("rst stall", {31'd0, StallM}, 32'd0);
    check("rst buserr", {31'd0, BusErrM}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // rd wr f3 addr wdata rdata ackAt be wdata-exp rd-exp
    doOp(1, 0, 3'b010, 32'h100, 32'h0, 32'h11223344, 1, 4'b1111, 32'h0, 32'h11223344);
    doOp(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 2, 4'b1000, 32'h0, 32'hFFFFFF80);
    doOp(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1, 4'b1000, 32'h0, 32'h00000080);
    doOp(1, 0, 3'b101, 32'h102, 32'h0, 32'hBEEF0000, 1, 4'b1100, 32'h0, 32'h0000BEEF);
    doOp(1, 0, 3'b001, 32'h100, 32'h0, 32'h12348001, 3, 4'b0011, 32'h0, 32'hFFFF8001);
    doOp(1, 0, 3'b000, 32'h100, 32'h0, 32'h0000007F, 1, 4'b0001, 32'h0, 32'h0000007F);
    doOp(0, 1, 3'b000, 32'h201, 32'hAABBCCDD, 32'h0, 1, 4'b0010, 32'hDDDDDDDD, 32'h0000007F);
    doOp(0, 1, 3'b001, 32'h202, 32'hAABBCCDD, 32'h0, 2, 4'b1100, 32'hCCDDCCDD, 32'h0000007F);
    doOp(0, 1, 3'b000, 32'h203, 32'h00000011, 32'h0, 1, 4'b1000, 32'h11111111, 32'h0000007F);
    // Store wins when both strobes are high.
    doOp(1, 1, 3'b010, 32'h204, 32'h01020304, 32'hFFFFFFFF, 1, 4'b1111, 32'h01020304, 32'h0000007F);

    doBad("lw unaligned", 1, 0, 3'b010, 32'h102);
    doBad("load f3 011", 1, 0, 3'b011, 32'h100);
    doBad("lh odd", 1, 0, 3'b001, 32'h101);
    doBad("store f3 100", 0, 1, 3'b100, 32'h200);

    // Watchdog: no ack for TMO BUSY cycles.
    doOp(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 0, 4'b1111, 32'h0, 32'hDEADBEEF);

    // Reset in the middle of an access whose ack would come late.
    begin
      reqExp_t re;
      re.we = 1'b0; re.addr = 32'h104; re.be = 4'b1111; re.wdata = 32'h0;
      reqQ.push_back(re);
      MemReadM   = 1'b1;
      funct3M    = 3'b010;
      ALUResultM = 32'h104;
      dmem_rdata = 32'h77777777;
      repeat (3) begin
        @(posedge clk); #1;
      end
      reset    = 1'b1;
      MemReadM = 1'b0;
      #1;
      check("midrst req", {31'd0, dmem_req}, 32'd0);
      check("midrst stall", {31'd0, StallM}, 32'd0);
      check("midrst ReadDataM", ReadDataM, 32'd0);
      check("midrst buserr", {31'd0, BusErrM}, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset    = 1'b0;
      expRd    = 32'h0;
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("late ack req", {31'd0, dmem_req}, 32'd0);
      check("late ack stall", {31'd0, StallM}, 32'd0);
      check("late ack ReadDataM", ReadDataM, 32'd0);
    end

    // Back-to-back load then store.
    doOp(1, 0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 1, 4'b1111, 32'h0, 32'hCAFEF00D);
    doOp(0, 1, 3'b010, 32'h108, 32'h01020304, 32'h0, 1, 4'b1111, 32'h01020304, 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    #1;
    check("req queue drained", reqQ.size(), 32'd0);
    check("done queue drained", cmpQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
